// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: CPU, loader and RAM side signals of the RAM arbiter.
// slave is the arbiter's view, master the surrounding system's view.
interface ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_privileged;
  logic              cpu_idle;
  logic              cpu_halt;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_rvalid;
  logic              ldr_hold_req;
  logic              ldr_hold_ack;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              starve;
  logic              prot_fault;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_privileged, cpu_idle,
    output cpu_rdata, cpu_halt,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_hold_req,
    output ldr_ack, ldr_rdata, ldr_rvalid, ldr_hold_ack,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output starve, prot_fault
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_privileged, cpu_idle,
    input  cpu_rdata, cpu_halt,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_hold_req,
    input  ldr_ack, ldr_rdata, ldr_rvalid, ldr_hold_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  starve, prot_fault
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port RAM between CPU and loader port.
// Define MEM_PROTECT_EN to block unprivileged CPU writes below PROT_LIMIT.
module ram_arbiter #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 16,
  parameter int                STARVE_LIMIT = 64,
  parameter logic [ADDR_W-1:0] PROT_LIMIT   = 16'h0010
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    CPU_OWN,
    HOLD_PEND,
    LOADER_OWN,
    RELEASE
  } state_t;

  state_t state_q, state_n;

  logic          halt_q;
  logic          hack_q;
  logic          rvalid_q;
  logic          starve_q;
  logic [CW-1:0] cnt_q, cnt_n;

  logic              ldr_own;
  logic              cpu_acc;
  logic              blocked;
  logic              cpu_go;
  logic              grant;
  logic              mux_en;
  logic              mux_we;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  assign ldr_own = (state_q == LOADER_OWN);
  assign cpu_acc = bus.cpu_rd | bus.cpu_wr;

`ifdef MEM_PROTECT_EN
  logic fault_q;

  // CPU accesses are ignored while the loader owns the bus, so no fault then
  assign blocked = ~ldr_own & bus.cpu_wr & ~bus.cpu_privileged
                 & (bus.cpu_addr < PROT_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= blocked;
  end

  assign bus.prot_fault = fault_q;
`else
  logic unused_prot;

  assign blocked        = 1'b0;
  assign unused_prot    = bus.cpu_privileged
                        ^ (bus.cpu_addr < PROT_LIMIT);
  assign bus.prot_fault = 1'b0;
`endif

  assign cpu_go = ~ldr_own & cpu_acc & ~blocked;
  assign grant  = bus.ldr_req & ~cpu_go;

  always_comb begin
    mux_en    = 1'b0;
    mux_we    = 1'b0;
    mux_addr  = bus.cpu_addr;
    mux_wdata = bus.cpu_wdata;
    if (cpu_go) begin
      mux_en = 1'b1;
      mux_we = bus.cpu_wr;
    end else if (grant) begin
      mux_en    = 1'b1;
      mux_we    = bus.ldr_we;
      mux_addr  = bus.ldr_addr;
      mux_wdata = bus.ldr_wdata;
    end
  end

  assign bus.ram_en    = mux_en;
  assign bus.ram_we    = mux_we;
  assign bus.ram_addr  = mux_addr;
  assign bus.ram_wdata = mux_wdata;
  assign bus.ldr_ack   = grant;
  assign bus.cpu_rdata = bus.ram_rdata;
  assign bus.ldr_rdata = bus.ram_rdata;

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      CPU_OWN: begin
        if (bus.ldr_hold_req) state_n = HOLD_PEND;
      end
      HOLD_PEND: begin
        if (!bus.ldr_hold_req)
          state_n = CPU_OWN;
        else if (bus.cpu_idle && !cpu_acc)
          state_n = LOADER_OWN;
      end
      LOADER_OWN: begin
        if (!bus.ldr_hold_req) state_n = RELEASE;
      end
      RELEASE: begin
        state_n = CPU_OWN;
      end
      default: state_n = CPU_OWN;
    endcase
  end

  always_comb begin
    cnt_n = cnt_q;
    if (grant)
      cnt_n = '0;
    else if (bus.ldr_req && cnt_q != CW'(STARVE_LIMIT))
      cnt_n = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= CPU_OWN;
      halt_q   <= 1'b0;
      hack_q   <= 1'b0;
      rvalid_q <= 1'b0;
      starve_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_n;
      // halt covers RELEASE so the last loader read can return
      halt_q   <= (state_n == LOADER_OWN) | (state_n == RELEASE);
      hack_q   <= (state_n == LOADER_OWN);
      rvalid_q <= grant & ~bus.ldr_we;
      starve_q <= (cnt_n == CW'(STARVE_LIMIT));
      cnt_q    <= cnt_n;
    end
  end

  assign bus.cpu_halt     = halt_q;
  assign bus.ldr_hold_ack = hack_q;
  assign bus.ldr_rvalid   = rvalid_q;
  assign bus.starve       = starve_q;

endmodule
